// File: rtl/tnoc_input_vc_requester.sv
// tnoc_input_vc_requester: per-VC head-packet tracker raising port/VC requests (sop, request, free, eop per [port][vc]) toward the routed output, popping the input FIFO while granted and discarding bad routes
module tnoc_input_vc_requester #(
    parameter int CHANNELS = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [CHANNELS-1:0]           i_fifo_valid,
    input  logic [CHANNELS-1:0]           i_fifo_head,
    input  logic [CHANNELS-1:0]           i_fifo_tail,
    input  logic [CHANNELS-1:0][4:0]      i_route,
    output logic [CHANNELS-1:0]           o_fifo_pop,
    output logic [CHANNELS-1:0][4:0]      o_port_select,
    input  logic [CHANNELS-1:0]           i_vc_ready,
    output logic [4:0][CHANNELS-1:0]      o_start_of_packet,
    output logic [4:0][CHANNELS-1:0]      o_request,
    output logic [4:0][CHANNELS-1:0]      o_free,
    output logic [4:0][CHANNELS-1:0]      o_end_of_packet,
    input  logic [4:0][CHANNELS-1:0]      i_grant,
    output logic [CHANNELS-1:0]           o_route_error
);
    typedef enum logic [1:0] {IDLE, REQUEST, ACTIVE, DISCARD} state_t;
    for (genvar c = 0; c < CHANNELS; c++) begin : g_vc
        state_t     st;
        logic [4:0] port;
        logic [4:0] grant;
        logic       err;
        logic       busy;
        logic       granted;
        logic       xfer;
        logic       eop;
        logic       onehot;
        for (genvar p = 0; p < 5; p++) begin : g_port
            assign grant[p]                = i_grant[p][c];
            assign o_start_of_packet[p][c] = (st == REQUEST) && port[p];
            assign o_request[p][c]         = busy && port[p];
            assign o_free[p][c]            = eop && port[p];
            assign o_end_of_packet[p][c]   = eop && port[p];
        end
        assign busy             = (st == REQUEST) || (st == ACTIVE);
        assign granted          = |(grant & port);
        assign xfer             = busy && i_fifo_valid[c] && granted && i_vc_ready[c];
        assign eop              = xfer && i_fifo_tail[c];
        assign o_fifo_pop[c]    = !i_rst && (xfer || (i_fifo_valid[c] && ((st == DISCARD) || ((st == IDLE) && !i_fifo_head[c]))));
        assign o_port_select[c] = busy ? port : '0;
        assign o_route_error[c] = err;
        assign onehot           = (i_route[c] != '0) && ((i_route[c] & (i_route[c] - 5'd1)) == '0);
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                st   <= IDLE;
                port <= '0;
                err  <= 1'b0;
            end else begin
                case (st)
                    IDLE: begin
                        if (i_fifo_valid[c] && i_fifo_head[c]) begin
                            port <= i_route[c];
                            st   <= onehot ? REQUEST : DISCARD;
                            err  <= err || !onehot;
                        end else if (i_fifo_valid[c]) begin
                            err  <= 1'b1;
                        end
                    end
                    REQUEST: st <= eop ? IDLE : granted ? ACTIVE : REQUEST;
                    ACTIVE:  st <= eop ? IDLE : ACTIVE;
                    DISCARD: st <= (i_fifo_valid[c] && i_fifo_tail[c]) ? IDLE : DISCARD;
                    default: st <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tnoc_input_vc_requester.sv
// tb_tnoc_input_vc_requester: directed and randomized checks of the requester against a packet-level reference model
module tb_tnoc_input_vc_requester;
    localparam int CH = 2;
    typedef struct packed {logic head; logic tail; logic [4:0] route;} flit_t;
    logic                clk = 1'b0;
    logic                rst;
    logic [CH-1:0]       fifo_valid, fifo_head, fifo_tail, fifo_pop, vc_ready, route_error;
    logic [CH-1:0][4:0]  route, port_select;
    logic [4:0][CH-1:0]  sop, request, free, eop, grant;
    int n_assert = 0;
    int n_fail = 0;
    // reference model: phase 0 idle, 1 waiting for first grant, 2 granted, 3 dropping bad packet
    int            phase [CH];
    int            pidx  [CH];
    logic [CH-1:0] merr;
    logic [CH-1:0] e_pop, e_xfer;
    flit_t         q [CH][$];

    tnoc_input_vc_requester #(.CHANNELS(CH)) dut (
        .i_clk(clk), .i_rst(rst), .i_fifo_valid(fifo_valid), .i_fifo_head(fifo_head),
        .i_fifo_tail(fifo_tail), .i_route(route), .o_fifo_pop(fifo_pop), .o_port_select(port_select),
        .i_vc_ready(vc_ready), .o_start_of_packet(sop), .o_request(request), .o_free(free),
        .o_end_of_packet(eop), .i_grant(grant), .o_route_error(route_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            phase[c] = 0;
            pidx[c]  = 0;
        end
        merr = '0;
    endtask

    task automatic model_check();
        logic [CH-1:0][4:0] e_sel;
        logic [4:0][CH-1:0] e_sop, e_req, e_free;
        e_sel = '0; e_sop = '0; e_req = '0; e_free = '0; e_pop = '0; e_xfer = '0;
        for (int c = 0; c < CH; c++) begin
            if (!rst && (phase[c] == 1 || phase[c] == 2)) begin
                e_sel[c][pidx[c]] = 1'b1;
                e_req[pidx[c]][c] = 1'b1;
                if (phase[c] == 1) e_sop[pidx[c]][c] = 1'b1;
                e_xfer[c] = fifo_valid[c] && grant[pidx[c]][c] && vc_ready[c];
                if (e_xfer[c] && fifo_tail[c]) e_free[pidx[c]][c] = 1'b1;
            end
            e_pop[c] = !rst && (e_xfer[c] || (fifo_valid[c] && (phase[c] == 3 || (phase[c] == 0 && !fifo_head[c]))));
        end
        chk("pop", 64'(fifo_pop), 64'(e_pop));
        chk("port_select", 64'(port_select), 64'(e_sel));
        chk("start_of_packet", 64'(sop), 64'(e_sop));
        chk("request", 64'(request), 64'(e_req));
        chk("free", 64'(free), 64'(e_free));
        chk("end_of_packet", 64'(eop), 64'(e_free));
        chk("route_error", 64'(route_error), 64'(merr));
    endtask

    task automatic model_update();
        for (int c = 0; c < CH; c++) begin
            if (phase[c] == 0 && fifo_valid[c] && fifo_head[c]) begin
                if ($countones(route[c]) == 1) begin
                    phase[c] = 1;
                    for (int p = 0; p < 5; p++) if (route[c][p]) pidx[c] = p;
                end else begin
                    phase[c] = 3;
                    merr[c]  = 1'b1;
                end
            end else if (phase[c] == 0 && fifo_valid[c]) merr[c] = 1'b1;
            else if ((phase[c] == 1 || phase[c] == 2) && e_xfer[c] && fifo_tail[c]) phase[c] = 0;
            else if (phase[c] == 1 && grant[pidx[c]][c]) phase[c] = 2;
            else if (phase[c] == 3 && fifo_valid[c] && fifo_tail[c]) phase[c] = 0;
        end
    endtask

    task automatic tick_check();
        #1;
        model_check();
    endtask

    task automatic tick_end();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic step();
        tick_check();
        tick_end();
    endtask

    task automatic drv(input int c, input logic v, input logic h, input logic t, input logic [4:0] r);
        fifo_valid[c] = v;
        fifo_head[c]  = h;
        fifo_tail[c]  = t;
        route[c]      = r;
    endtask

    task automatic refill(input int c);
        int    len;
        logic [4:0] r;
        flit_t f;
        len = $urandom_range(1, 4);
        r = ($urandom_range(0, 4) != 0) ? 5'(1 << $urandom_range(0, 4)) : 5'($urandom_range(0, 31) & 5'b10110);
        if ($urandom_range(0, 19) == 0) begin
            f = '{head: 1'b0, tail: 1'b1, route: 5'd0};
            q[c].push_back(f);
        end
        for (int i = 0; i < len; i++) begin
            f = '{head: (i == 0), tail: (i == len - 1), route: r};
            q[c].push_back(f);
        end
    endtask

    initial begin
        rst = 1'b1;
        fifo_valid = '0; fifo_head = '0; fifo_tail = '0; route = '0; vc_ready = '1; grant = '0;
        model_reset();
        @(negedge clk);
        tick_check();
        @(negedge clk);
        rst = 1'b0;

        // single-VC 3-flit packet, route 5'b00100, grant from cycle 2
        drv(0, 1, 1, 0, 5'b00100);
        step();
        tick_check();
        chk("t1_sop_c1", 64'(sop[2][0]), 64'd1);
        chk("t1_pop_c1", 64'(fifo_pop[0]), 64'd0);
        tick_end();
        grant[2][0] = 1'b1;
        tick_check();
        chk("t1_pop_c2", 64'(fifo_pop[0]), 64'd1);
        tick_end();
        drv(0, 1, 0, 0, 5'b00000);
        tick_check();
        chk("t1_sop_c3", 64'(sop[2][0]), 64'd0);
        chk("t1_req_c3", 64'(request[2][0]), 64'd1);
        tick_end();
        drv(0, 1, 0, 1, 5'b00000);
        tick_check();
        chk("t1_free_c4", 64'(free), 64'(1 << (2 * CH)));
        tick_end();
        drv(0, 0, 0, 0, 5'b00000);
        grant = '0;
        step();

        // bad route on a 2-flit packet: dropped without requests, sticky error
        drv(1, 1, 1, 0, 5'b00110);
        step();
        tick_check();
        chk("t3_pop_c1", 64'(fifo_pop[1]), 64'd1);
        tick_end();
        drv(1, 1, 0, 1, 5'b00000);
        step();
        drv(1, 0, 0, 0, 5'b00000);
        tick_check();
        chk("t3_err", 64'(route_error), 64'b10);
        tick_end();

        // reset asserted while VC0 is ACTIVE
        drv(0, 1, 1, 0, 5'b10000);
        grant[4][0] = 1'b1;
        step();
        step();
        drv(0, 1, 0, 0, 5'b00000);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_request", 64'(request), 64'd0);
        chk("rst_free", 64'(free), 64'd0);
        chk("rst_pop", 64'(fifo_pop), 64'd0);
        chk("rst_error", 64'(route_error), 64'd0);
        @(negedge clk);
        drv(0, 0, 0, 0, 5'b00000);
        @(negedge clk);
        rst = 1'b0;
        drv(0, 1, 1, 0, 5'b10000);
        step();
        tick_check();
        chk("rst_restart_sop", 64'(sop[4][0]), 64'd1);
        tick_end();
        drv(0, 1, 0, 1, 5'b00000);
        step();
        drv(0, 0, 0, 0, 5'b00000);
        grant = '0;
        step();

        // randomized traffic on all VCs
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < CH; c++) begin
                if (q[c].size() == 0) refill(c);
                if ($urandom_range(0, 3) != 0)
                    drv(c, 1, q[c][0].head, q[c][0].tail, q[c][0].route);
                else
                    drv(c, 0, 0, 0, 5'($urandom_range(0, 31)));
                vc_ready[c] = ($urandom_range(0, 3) != 0);
            end
            grant = 10'($urandom_range(0, 1023) | $urandom_range(0, 1023));
            tick_check();
            for (int c = 0; c < CH; c++) if (e_pop[c]) void'(q[c].pop_front());
            tick_end();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
